// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: codeword bit positions and the encoder.
// Bit index in a codeword is the Hamming position minus one.
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int CODE_W = 7;

    localparam int P1_BIT = 0;
    localparam int P2_BIT = 1;
    localparam int D0_BIT = 2;
    localparam int P4_BIT = 3;
    localparam int D1_BIT = 4;
    localparam int D2_BIT = 5;
    localparam int D3_BIT = 6;

    // Even-parity encoder; the decoder's syndrome logic reuses it.
    function automatic logic [CODE_W-1:0] ham74_enc(
        input logic [DATA_W-1:0] d
    );
        logic [CODE_W-1:0] c;
        c         = '0;
        c[D0_BIT] = d[0];
        c[D1_BIT] = d[1];
        c[D2_BIT] = d[2];
        c[D3_BIT] = d[3];
        c[P1_BIT] = d[0] ^ d[1] ^ d[3];
        c[P2_BIT] = d[0] ^ d[2] ^ d[3];
        c[P4_BIT] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

endpackage

// File: rtl/hamming_sync_fifo.sv
// Synchronous FIFO; occupancy counter is the only full/empty source.
// Ports: wr_en/wr_data push, rd_en pops, rd_data is the head (0 when empty).
module hamming_sync_fifo #(
    parameter  int WIDTH = 7,
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_wr;
    logic             do_rd;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Power-of-two depth: pointers wrap by overflow.
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    assign level   = level_q;

endmodule

// File: rtl/hamming_enc_fifo.sv
// Hamming(7,4) encoder feeding a codeword FIFO, with one-shot error inject.
// Ports: in_* nibble handshake, inj_* injection arm, out_* codeword handshake.
module hamming_enc_fifo
    import hamming_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int CNT_W = 16,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inj_load,
    input  logic [CODE_W-1:0] inj_mask,
    output logic              inj_pending,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [LVL_W-1:0]  level,
    output logic [CNT_W-1:0]  sent_cnt
);

    logic [CODE_W-1:0] mask_q, mask_d;
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] wr_code;
    logic              accept;
    logic              pop;
    logic              full;
    logic              empty;

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign wr_code = ham74_enc(in_data) ^ (pend_q ? mask_q : '0);

    always_comb begin
        mask_d = mask_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        if (accept) pend_d = 1'b0;
        // A load coinciding with an accept arms the following word.
        if (inj_load) begin
            mask_d = inj_mask;
            pend_d = 1'b1;
        end
        if (pop) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            mask_q <= mask_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    hamming_sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_data (wr_code),
        .rd_en   (pop),
        .rd_data (out_code),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    assign inj_pending = pend_q;
    assign sent_cnt    = cnt_q;

endmodule

// File: tb/tb_hamming_enc_fifo.sv
// Scoreboard bench for hamming_enc_fifo: handshakes are sampled on the
// falling edge, expected codewords come from an independent reference model.
module tb_hamming_enc_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_data = '0;
    logic        inj_load = 1'b0;
    logic [6:0]  inj_mask = '0;
    logic        inj_pending;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [6:0]  out_code;
    logic [2:0]  level;
    logic [15:0] sent_cnt;

    int errors = 0;
    int checks = 0;

    logic [6:0] sb_q[$];
    logic       m_pend = 1'b0;
    logic [6:0] m_mask = '0;

    always #5 clk = ~clk;

    hamming_enc_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .inj_load    (inj_load),
        .inj_mask    (inj_mask),
        .inj_pending (inj_pending),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .level       (level),
        .sent_cnt    (sent_cnt)
    );

    // Positional Hamming construction: data fills non-power-of-two
    // positions, parity k covers every position with bit k set.
    function automatic logic [6:0] ref_enc(input logic [3:0] d);
        logic [6:0] c;
        logic       p;
        int         j;
        c = '0;
        j = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if (pos != 1 && pos != 2 && pos != 4) begin
                c[pos-1] = d[j];
                j++;
            end
        end
        for (int k = 1; k <= 4; k = k * 2) begin
            p = 1'b0;
            for (int pos = 1; pos <= 7; pos++)
                if ((pos & k) != 0 && pos != k) p ^= c[pos-1];
            c[k-1] = p;
        end
        return c;
    endfunction

    // Scoreboard monitor: compares pops, then records pushes.
    always @(negedge clk) begin
        logic [6:0] exp_c;
        if (rst) begin
            sb_q.delete();
            m_pend = 1'b0;
            m_mask = '0;
        end else begin
            checks++;
            if (level !== 3'(sb_q.size())) begin
                errors++;
                $display("FAIL sb_level: got %0d want %0d",
                         level, sb_q.size());
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop: got %b want <none>", out_code);
                end else begin
                    exp_c = sb_q.pop_front();
                    if (out_code !== exp_c) begin
                        errors++;
                        $display("FAIL sb_code: got %b want %b",
                                 out_code, exp_c);
                    end
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                exp_c = ref_enc(in_data) ^ (m_pend ? m_mask : 7'd0);
                sb_q.push_back(exp_c);
                m_pend = 1'b0;
            end
            if (inj_load) begin
                m_mask = inj_mask;
                m_pend = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_hold(input logic [3:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) done = 1'b1;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL push_timeout: got in_ready=0 want accept");
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            if (!out_valid) break;
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || level !== 3'd0 ||
            sent_cnt !== 16'd0 || out_code !== 7'd0 || inj_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset: got v=%b r=%b l=%0d c=%0d o=%b p=%b want 0 1 0 0 0 0",
                     out_valid, in_ready, level, sent_cnt, out_code, inj_pending);
        end
    endtask

    task automatic test_encode();
        logic [3:0] din [3];
        logic [6:0] want [3];
        din[0] = 4'b1011; want[0] = 7'b1010101;
        din[1] = 4'b0000; want[1] = 7'b0000000;
        din[2] = 4'b1111; want[2] = 7'b1111111;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = din[i];
            step();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_code !== want[i]) begin
                errors++;
                $display("FAIL encode_%0d: got v=%b %b want 1 %b",
                         i, out_valid, out_code, want[i]);
            end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_hold(4'(i + 3));
        checks++;
        if (in_ready !== 1'b0 || level !== 3'd4) begin
            errors++;
            $display("FAIL fill_full: got r=%b l=%0d want 0 4", in_ready, level);
        end
        in_valid = 1'b1;
        in_data  = 4'hC;
        step();
        step();
        checks++;
        if (level !== 3'd4) begin
            errors++;
            $display("FAIL fill_hold: got l=%0d want 4", level);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (level !== 3'd3 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_pop: got l=%0d r=%b want 3 1", level, in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (level !== 3'd4) begin
            errors++;
            $display("FAIL fill_late: got l=%0d want 4", level);
        end
        drain();
    endtask

    task automatic test_inject();
        inj_load = 1'b1;
        inj_mask = 7'b0000100;
        step();
        inj_load = 1'b0;
        checks++;
        if (inj_pending !== 1'b1) begin
            errors++;
            $display("FAIL inj_arm: got %b want 1", inj_pending);
        end
        push_hold(4'b1011);
        checks++;
        if (out_code !== 7'b1010001 || inj_pending !== 1'b0) begin
            errors++;
            $display("FAIL inj_word: got %b p=%b want 1010001 0",
                     out_code, inj_pending);
        end
        push_hold(4'b1011);
        drain();
        // Load coinciding with an accept arms the following word.
        in_valid = 1'b1;
        in_data  = 4'b0000;
        inj_load = 1'b1;
        inj_mask = 7'b1000000;
        step();
        inj_load = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_code !== 7'b0000000 || inj_pending !== 1'b1) begin
            errors++;
            $display("FAIL inj_coincide: got %b p=%b want 0000000 1",
                     out_code, inj_pending);
        end
        push_hold(4'b0000);
        drain();
    endtask

    task automatic test_simul();
        out_ready = 1'b0;
        push_hold(4'h1);
        push_hold(4'h2);
        in_valid  = 1'b1;
        in_data   = 4'h3;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (level !== 3'd2) begin
            errors++;
            $display("FAIL simul_level: got %0d want 2", level);
        end
        push_hold(4'h4);
        push_hold(4'h5);
        in_valid  = 1'b1;
        in_data   = 4'h6;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (level !== 3'd3) begin
            errors++;
            $display("FAIL simul_fullpop: got %0d want 3", level);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (level !== 3'd4) begin
            errors++;
            $display("FAIL simul_accept: got %0d want 4", level);
        end
        drain();
    endtask

    task automatic test_midreset();
        out_ready = 1'b0;
        push_hold(4'h7);
        push_hold(4'h8);
        push_hold(4'h9);
        inj_load = 1'b1;
        inj_mask = 7'b0000001;
        step();
        inj_load = 1'b0;
        checks++;
        if (level !== 3'd3 || sent_cnt === 16'd0) begin
            errors++;
            $display("FAIL mid_pre: got l=%0d c=%0d want 3 nonzero",
                     level, sent_cnt);
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'hA;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (level !== 3'd0 || out_valid !== 1'b0 || sent_cnt !== 16'd0 ||
            in_ready !== 1'b1 || inj_pending !== 1'b0 || out_code !== 7'd0) begin
            errors++;
            $display("FAIL mid_reset: got l=%0d v=%b c=%0d r=%b p=%b o=%b want 0 0 0 1 0 0",
                     level, out_valid, sent_cnt, in_ready, inj_pending, out_code);
        end
        push_hold(4'b0000);
        drain();
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 4'($urandom_range(15));
        step();
        for (int i = 0; i < 65535; i++) begin
            in_data = 4'($urandom_range(15));
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (sent_cnt !== 16'hFFFF || level !== 3'd1) begin
            errors++;
            $display("FAIL wrap_max: got c=%h l=%0d want ffff 1", sent_cnt, level);
        end
        step();
        out_ready = 1'b0;
        checks++;
        if (sent_cnt !== 16'h0000 || level !== 3'd0) begin
            errors++;
            $display("FAIL wrap_zero: got c=%h l=%0d want 0000 0", sent_cnt, level);
        end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_fill();
        test_inject();
        test_simul();
        test_midreset();
        test_wrap();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
